// File: rtl/zl_fifo_sc_pkg.sv
// Shared defaults and helpers for the single-clock show-ahead FIFO.
// Default geometry, threshold defaults, sticky flag bit positions and the level-update helper.
package zl_fifo_sc_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_AFULL_MARGIN  = 2;
  localparam int DEF_AEMPTY_THRESH = 2;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_UDF  = 1;
  localparam int NUM_FLAGS = 2;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'b00,
    LVL_INC  = 2'b01,
    LVL_DEC  = 2'b10
  } lvl_op_e;

  // Simultaneous increment and decrement cancel out.
  function automatic lvl_op_e level_op(input logic inc, input logic dec);
    lvl_op_e op;
    if (inc && !dec) begin
      op = LVL_INC;
    end else if (dec && !inc) begin
      op = LVL_DEC;
    end else begin
      op = LVL_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/zl_fifo_sc_if.sv
// req/ack stream bundle used on both sides of the FIFO.
// The master drives req/data, the slave answers with ack.
interface zl_fifo_sc_if
  import zl_fifo_sc_pkg::*;
#(
  parameter int Data_width = DEF_DATA_WIDTH
);

  logic                  req;
  logic                  ack;
  logic [Data_width-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);

endinterface

// File: rtl/zl_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Read-during-write to the same address returns the old word.
module zl_sdp_ram
  import zl_fifo_sc_pkg::*;
#(
  parameter int Data_width = DEF_DATA_WIDTH,
  parameter int Addr_width = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [Addr_width-1:0] wr_addr,
  input  logic [Data_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [Addr_width-1:0] rd_addr,
  output logic [Data_width-1:0] rd_data
);

  localparam int DEPTH = 2 ** Addr_width;

  logic [Data_width-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/zl_fifo_sc.sv
// Single-clock show-ahead FIFO with programmable almost-full/almost-empty, sticky
// overflow/underflow and synchronous flush; a RAM feeds a 2-entry prefetch/output pipeline.
module zl_fifo_sc
  import zl_fifo_sc_pkg::*;
#(
  parameter int Data_width    = DEF_DATA_WIDTH,
  parameter int Addr_width    = DEF_ADDR_WIDTH,
  parameter int Afull_thresh  = (2 ** Addr_width) - DEF_AFULL_MARGIN,
  parameter int Aempty_thresh = DEF_AEMPTY_THRESH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  zl_fifo_sc_if.slave         in_if,
  zl_fifo_sc_if.master        out_if,
  output logic                in_full,
  output logic                in_afull,
  output logic                out_aempty,
  output logic [Addr_width:0] used,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 2 ** Addr_width;
  localparam logic [Addr_width:0]   LVL_ZERO_L = {(Addr_width + 1){1'b0}};
  localparam logic [Addr_width:0]   LVL_ONE_L  = {{Addr_width{1'b0}}, 1'b1};
  localparam logic [Addr_width-1:0] PTR_ZERO_L = {Addr_width{1'b0}};
  localparam logic [Addr_width-1:0] PTR_ONE_L  = {{(Addr_width - 1){1'b0}}, 1'b1};
  localparam logic [Addr_width:0]   DEPTH_L    = (Addr_width + 1)'(DEPTH);
  localparam logic [Addr_width:0]   AFULL_L    = (Addr_width + 1)'(Afull_thresh);
  localparam logic [Addr_width:0]   AEMPTY_L   = (Addr_width + 1)'(Aempty_thresh);
  localparam logic                  AFULL_AT_ZERO_L = (Afull_thresh == 0);

  logic [Addr_width-1:0] wr_ptr_r;
  logic [Addr_width-1:0] rd_ptr_r;
  logic [Addr_width:0]   ram_cnt_r;
  logic [Addr_width:0]   used_r;
  logic                  rd_vld_r;
  logic                  out_vld_r;
  logic                  pf_vld_r;
  logic [Data_width-1:0] out_data_r;
  logic [Data_width-1:0] pf_data_r;
  logic                  in_full_r;
  logic                  in_afull_r;
  logic                  out_aempty_r;
  logic [NUM_FLAGS-1:0]  sticky_r;

  logic                  wr_en_s;
  logic                  pop_s;
  logic                  rd_en_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [1:0]            occ_next_s;
  logic [Addr_width:0]   used_next_s;
  logic [Addr_width:0]   ram_cnt_next_s;
  logic [Data_width-1:0] ram_rd_data_s;
  logic                  out_vld_next_s;
  logic                  pf_vld_next_s;
  logic [Data_width-1:0] out_data_next_s;
  logic [Data_width-1:0] pf_data_next_s;

  function automatic logic [Addr_width:0] level_next(input logic [Addr_width:0] lvl,
                                                     input logic inc, input logic dec);
    logic [Addr_width:0] nxt;
    case (level_op(inc, dec))
      LVL_INC: nxt = lvl + LVL_ONE_L;
      LVL_DEC: nxt = lvl - LVL_ONE_L;
      default: nxt = lvl;
    endcase
    return nxt;
  endfunction

  zl_sdp_ram #(
    .Data_width (Data_width),
    .Addr_width (Addr_width)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we_s),
    .wr_addr (wr_ptr_r),
    .wr_data (in_if.data),
    .rd_en   (ram_re_s),
    .rd_addr (rd_ptr_r),
    .rd_data (ram_rd_data_s)
  );

  // Handshake qualification, read issue and next fill levels.
  // A read is issued only if its word is guaranteed a slot in out/prefetch when it lands.
  always_comb begin
    wr_en_s        = in_if.req & ~in_full_r;
    pop_s          = out_if.ack & out_vld_r;
    occ_next_s     = {1'b0, out_vld_r} + {1'b0, pf_vld_r} + {1'b0, rd_vld_r} - {1'b0, pop_s};
    rd_en_s        = (ram_cnt_r != LVL_ZERO_L) && (occ_next_s <= 2'd1);
    ram_we_s       = wr_en_s & ~flush;
    ram_re_s       = rd_en_s & ~flush;
    used_next_s    = level_next(used_r, wr_en_s, pop_s);
    ram_cnt_next_s = level_next(ram_cnt_r, wr_en_s, rd_en_s);
  end

  // Output/prefetch steering: the output register refills from prefetch first, then from RAM.
  always_comb begin
    out_vld_next_s  = out_vld_r;
    out_data_next_s = out_data_r;
    pf_vld_next_s   = pf_vld_r;
    pf_data_next_s  = pf_data_r;
    if (!out_vld_r || pop_s) begin
      if (pf_vld_r) begin
        out_vld_next_s  = 1'b1;
        out_data_next_s = pf_data_r;
        pf_vld_next_s   = rd_vld_r;
        pf_data_next_s  = rd_vld_r ? ram_rd_data_s : pf_data_r;
      end else if (rd_vld_r) begin
        out_vld_next_s  = 1'b1;
        out_data_next_s = ram_rd_data_s;
      end else begin
        out_vld_next_s  = 1'b0;
      end
    end else if (rd_vld_r) begin
      pf_vld_next_s  = 1'b1;
      pf_data_next_s = ram_rd_data_s;
    end else begin
      pf_vld_next_s  = pf_vld_r;
    end
  end

  // State update; flush outranks every write, pop and flag event in its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= PTR_ZERO_L;
      rd_ptr_r     <= PTR_ZERO_L;
      ram_cnt_r    <= LVL_ZERO_L;
      used_r       <= LVL_ZERO_L;
      rd_vld_r     <= 1'b0;
      out_vld_r    <= 1'b0;
      pf_vld_r     <= 1'b0;
      out_data_r   <= {Data_width{1'b0}};
      pf_data_r    <= {Data_width{1'b0}};
      in_full_r    <= 1'b0;
      in_afull_r   <= AFULL_AT_ZERO_L;
      out_aempty_r <= 1'b1;
      sticky_r     <= {NUM_FLAGS{1'b0}};
    end else if (flush) begin
      wr_ptr_r     <= PTR_ZERO_L;
      rd_ptr_r     <= PTR_ZERO_L;
      ram_cnt_r    <= LVL_ZERO_L;
      used_r       <= LVL_ZERO_L;
      rd_vld_r     <= 1'b0;
      out_vld_r    <= 1'b0;
      pf_vld_r     <= 1'b0;
      in_full_r    <= 1'b0;
      in_afull_r   <= AFULL_AT_ZERO_L;
      out_aempty_r <= 1'b1;
      sticky_r     <= {NUM_FLAGS{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_L;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_L;
      end
      ram_cnt_r    <= ram_cnt_next_s;
      used_r       <= used_next_s;
      rd_vld_r     <= rd_en_s;
      out_vld_r    <= out_vld_next_s;
      out_data_r   <= out_data_next_s;
      pf_vld_r     <= pf_vld_next_s;
      pf_data_r    <= pf_data_next_s;
      in_full_r    <= (used_next_s == DEPTH_L);
      in_afull_r   <= (used_next_s >= AFULL_L);
      out_aempty_r <= (used_next_s <= AEMPTY_L);
      sticky_r[FLAG_OVF] <= sticky_r[FLAG_OVF] | (in_if.req & in_full_r);
      sticky_r[FLAG_UDF] <= sticky_r[FLAG_UDF] | (out_if.ack & ~out_vld_r);
    end
  end

  assign in_if.ack   = in_if.req & ~in_full_r;
  assign out_if.req  = out_vld_r;
  assign out_if.data = out_data_r;
  assign in_full     = in_full_r;
  assign in_afull    = in_afull_r;
  assign out_aempty  = out_aempty_r;
  assign used        = used_r;
  assign overflow    = sticky_r[FLAG_OVF];
  assign underflow   = sticky_r[FLAG_UDF];

endmodule

// File: tb/tb_zl_fifo_sc.sv
// Directed bench for zl_fifo_sc: a 16-deep instance for reset/latency steps and a
// 4-deep instance driven cycle by cycle against a latency-aware scoreboard queue.
module tb_zl_fifo_sc;
  import zl_fifo_sc_pkg::*;

  localparam int SD = 4;

  typedef struct {
    logic [7:0] data;
    int         rdy;
  } ent_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic b_flush = 1'b0;
  logic s_flush = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   m_used  = 0;
  logic m_ovf   = 1'b0;
  logic m_udf   = 1'b0;
  ent_t q[$];

  logic       b_full, b_afull, b_aempty, b_ovf, b_udf;
  logic [4:0] b_used;
  logic       s_full, s_afull, s_aempty, s_ovf, s_udf;
  logic [2:0] s_used;

  zl_fifo_sc_if #(.Data_width(8)) b_in ();
  zl_fifo_sc_if #(.Data_width(8)) b_out ();
  zl_fifo_sc_if #(.Data_width(8)) s_in ();
  zl_fifo_sc_if #(.Data_width(8)) s_out ();

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  zl_fifo_sc #(.Data_width(8), .Addr_width(4)) u_big (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_if(b_in), .out_if(b_out),
    .in_full(b_full), .in_afull(b_afull), .out_aempty(b_aempty), .used(b_used),
    .overflow(b_ovf), .underflow(b_udf)
  );

  zl_fifo_sc #(.Data_width(8), .Addr_width(2)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_if(s_in), .out_if(s_out),
    .in_full(s_full), .in_afull(s_afull), .out_aempty(s_aempty), .used(s_used),
    .overflow(s_ovf), .underflow(s_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the small FIFO; a word written before edge N is poppable once N+2 has passed.
  task automatic s_cycle(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
    logic exp_req, exp_ack, pop;
    s_in.req  = wr;
    s_in.data = d;
    s_out.ack = rd;
    s_flush   = fl;
    #1;
    exp_req = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("s_out_req", s_out.req, exp_req);
    if (exp_req) chk("s_out_data", s_out.data, q[0].data);
    exp_ack = wr && (m_used < SD);
    chk("s_in_ack", s_in.ack, exp_ack);
    pop = rd && exp_req;
    if (fl) begin
      q.delete();
      m_used = 0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      if (wr && m_used == SD) m_ovf = 1'b1;
      if (rd && !exp_req) m_udf = 1'b1;
      if (pop) void'(q.pop_front());
      if (exp_ack) q.push_back('{data: d, rdy: cyc + 3});
      m_used = m_used + (exp_ack ? 1 : 0) - (pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
    s_in.req  = 1'b0;
    s_out.ack = 1'b0;
    s_flush   = 1'b0;
    chk("s_used", s_used, m_used);
    chk("s_in_full", s_full, m_used == SD);
    chk("s_in_afull", s_afull, m_used >= 2);
    chk("s_out_aempty", s_aempty, m_used <= 2);
    chk("s_overflow", s_ovf, m_ovf);
    chk("s_underflow", s_udf, m_udf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b_in.req = 1'b0;  b_in.data = 8'h00;  b_out.ack = 1'b0;
    s_in.req = 1'b0;  s_in.data = 8'h00;  s_out.ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // reset state
    chk("rst_s_used", s_used, 0);
    chk("rst_s_out_req", s_out.req, 0);
    chk("rst_s_out_data", s_out.data, 0);
    chk("rst_s_aempty", s_aempty, 1);
    chk("rst_s_afull", s_afull, 0);
    chk("rst_s_full", s_full, 0);
    chk("rst_s_flags", {s_ovf, s_udf}, 0);

    // reset in the middle of traffic on the deep instance
    b_out.ack = 1'b1;
    @(posedge clk); #1;
    b_out.ack = 1'b0;
    chk("b_udf_set", b_udf, 1);
    b_in.req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in.data = 8'h10 + 8'(i);
      @(posedge clk); #1;
    end
    b_in.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b_used5", b_used, 5);
    chk("b_out_req_busy", b_out.req, 1);
    rst_n = 1'b0;
    #1;
    chk("b_rst_used", b_used, 0);
    chk("b_rst_out_req", b_out.req, 0);
    chk("b_rst_aempty", b_aempty, 1);
    chk("b_rst_flags", {b_ovf, b_udf}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("b_post_rst_used", b_used, 0);
    chk("b_post_rst_out_req", b_out.req, 0);

    // single-word latency into an empty FIFO
    b_in.req  = 1'b1;
    b_in.data = 8'h5A;
    @(posedge clk); #1;
    b_in.req = 1'b0;
    chk("lat_n", b_out.req, 0);
    chk("lat_used", b_used, 1);
    @(posedge clk); #1;
    chk("lat_n1", b_out.req, 0);
    @(posedge clk); #1;
    chk("lat_n2_req", b_out.req, 1);
    chk("lat_n2_data", b_out.data, 8'h5A);
    b_out.ack = 1'b1;
    @(posedge clk); #1;
    b_out.ack = 1'b0;
    chk("lat_pop_req", b_out.req, 0);
    chk("lat_pop_used", b_used, 0);
    chk("lat_pop_udf", b_udf, 0);

    // fill the 4-deep FIFO, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) s_cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    s_cycle(1'b1, 8'hA4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // continuous write+pop with counter data at constant level
    for (int i = 0; i < 3; i++) s_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 3; i < 3 + 3 * SD; i++) s_cycle(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // full with write and pop in the same cycle: pop only, then space opens
    for (int i = 0; i < 4; i++) s_cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    s_cycle(1'b1, 8'hE0, 1'b1, 1'b0);
    s_cycle(1'b1, 8'hE1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // drain to empty, pop on empty, flush clears
    for (int i = 0; i < 3; i++) s_cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) s_cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    s_cycle(1'b1, 8'h77, 1'b1, 1'b1);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // write + ack on empty: write kept, ack ignored
    s_cycle(1'b1, 8'h99, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
